// File: rtl/cache_axi_line_port.sv
// rtl/cache_axi_line_port.sv - cache line refill/writeback port onto single-ID AXI INCR bursts
//
// Converts whole-line cache requests into LINE_WORDS x 32-bit AXI bursts.
//   Read side : rd_req/rd_addr/rd_rdy in, ret_valid/ret_data out (line reassembled from R beats).
//   Write side: wr_req/wr_addr/wr_data/wr_rdy in, wr_valid out (pulse once B has been accepted).
//   AXI master: AR (araddr/arvalid/arready), R (rdata/rvalid/rready),
//               AW (awaddr/awvalid/awready), W (wdata/wlast/wvalid/wready), B (bvalid/bready).
//   clk, resetn: clock and asynchronous active-low reset.
// Fixed burst attributes (id, size, burst type, length, strobes) are tied off by the wrapper.

module cache_axi_line_port #(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rd_req,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  input  logic                     wr_req,
  input  logic [31:0]              wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     wr_valid,
  output logic [31:0]              araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [31:0]              awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int LW  = 32 * LINE_WORDS;
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int CW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
  localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFF) - 32'd1);

  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3;
  localparam logic [1:0] W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;

  logic [1:0]    rstate, wstate;
  logic [CW-1:0] rcnt, wcnt;
  logic [31:0]   rline, wline;
  logic [LW-1:0] rbuf, wbuf;
  logic          wr_valid_q;
  logic          wr_busy;
  logic          same_line;

  // The writeback counts as pending through its wr_valid cycle, so a refill
  // of the same line is only issued once the B response has been reported.
  assign wr_busy   = (wstate != W_IDLE) || wr_valid_q;
  assign same_line = ((rd_addr & LINE_MASK) == wline);
  assign rd_rdy    = (rstate == R_IDLE) && !(wr_busy && same_line);
  assign wr_rdy    = (wstate == W_IDLE);

  // Read FSM: AR handshake, then LINE_WORDS beats written into rbuf in order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      rline  <= '0;
      rbuf   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            rline  <= rd_addr & LINE_MASK;
            rstate <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            rcnt   <= '0;
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
              if (rcnt == CW'(i)) rbuf[32*i +: 32] <= rdata;
            end
            if (rcnt == LAST_BEAT) begin
              rcnt   <= '0;
              rstate <= R_DONE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW first, then W beats from the latched line, then wait for B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate     <= W_IDLE;
      wcnt       <= '0;
      wline      <= '0;
      wbuf       <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= (wstate == W_RESP) && bvalid;
      case (wstate)
        W_IDLE: begin
          if (wr_req) begin
            wline  <= wr_addr & LINE_MASK;
            wbuf   <= wr_data;
            wcnt   <= '0;
            wstate <= W_AW;
          end
        end
        W_AW: begin
          if (awready) wstate <= W_DATA;
        end
        W_DATA: begin
          if (wready) begin
            if (wcnt == LAST_BEAT) begin
              wcnt   <= '0;
              wstate <= W_RESP;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: begin
          if (bvalid) wstate <= W_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (wcnt == CW'(i)) wdata = wbuf[32*i +: 32];
    end
  end

  assign araddr    = rline;
  assign arvalid   = (rstate == R_AR);
  assign rready    = (rstate == R_DATA);
  assign ret_valid = (rstate == R_DONE);
  assign ret_data  = rbuf;
  assign awaddr    = wline;
  assign awvalid   = (wstate == W_AW);
  assign wvalid    = (wstate == W_DATA);
  assign wlast     = (wstate == W_DATA) && (wcnt == LAST_BEAT);
  assign bready    = (wstate == W_RESP);
  assign wr_valid  = wr_valid_q;

endmodule

// File: tb/tb_cache_axi_line_port.sv
// tb/tb_cache_axi_line_port.sv - directed bench for cache_axi_line_port with an AXI slave responder

module tb_cache_axi_line_port;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_valid;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  cache_axi_line_port #(.LINE_WORDS(4)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .wr_valid(wr_valid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave responder state
  logic        stall_en = 1'b0;
  int          bdelay   = 3;
  int          ridx     = 0;
  int          widx     = 0;
  logic        ar_fire = 1'b0, r_fire = 1'b0, aw_fire = 1'b0, w_fire = 1'b0, b_fire = 1'b0;
  logic        wl_fire = 1'b0;
  logic        ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, r_hold = 1'b0;
  logic [31:0] araddr_p = '0, awaddr_p = '0, wdata_p = '0;
  logic        wlast_p = 1'b0;
  logic [31:0] ar_cap = '0, aw_cap = '0;
  logic [31:0] wcap [4];
  logic        aw_seen = 1'b0;
  logic        bpend   = 1'b0;
  int          btimer  = 0;

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int k = 0; k < 4; k++) wcap[k] = '0;
    forever begin
      @(posedge clk);
      if (r_fire) ridx++;
      if (w_fire) widx++;
      if (aw_fire) aw_seen = 1'b1;
      if (wl_fire) begin
        bpend  = 1'b1;
        btimer = stall_en ? int'($urandom_range(0, 5)) : bdelay;
      end
      if (b_fire) begin
        bpend   = 1'b0;
        aw_seen = 1'b0;
      end

      @(negedge clk);
      if (ar_hold) begin
        check("ar_valid_held", arvalid, 1'b1);
        check("ar_addr_stable", araddr, araddr_p);
      end
      if (aw_hold) begin
        check("aw_valid_held", awvalid, 1'b1);
        check("aw_addr_stable", awaddr, awaddr_p);
      end
      if (w_hold) begin
        check("w_valid_held", wvalid, 1'b1);
        check("w_data_stable", wdata, wdata_p);
        check("w_last_stable", wlast, wlast_p);
      end
      if (b_fire || wr_valid) check("wr_valid_after_b", wr_valid, b_fire);

      arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready  = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (!r_hold) rvalid = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      rdata = 32'h0000_00A0 + 32'(ridx);
      if (bpend && btimer > 0) btimer--;
      bvalid = bpend && (btimer == 0);

      #1;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      wl_fire = w_fire && wlast;
      b_fire  = bvalid && bready;
      if (ar_fire) ar_cap = araddr;
      if (aw_fire) aw_cap = awaddr;
      if (wvalid) check("w_after_aw", aw_seen, 1'b1);
      if (w_fire) begin
        wcap[widx % 4] = wdata;
        check("wlast_beat", wlast, (widx % 4) == 3);
      end
      ar_hold  = arvalid && !arready;
      aw_hold  = awvalid && !awready;
      w_hold   = wvalid && !wready;
      r_hold   = rvalid && !r_fire;
      araddr_p = araddr;
      awaddr_p = awaddr;
      wdata_p  = wdata;
      wlast_p  = wlast;
    end
  end

  function automatic logic [127:0] exp_line(input int base);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = 32'h0000_00A0 + 32'(base + k);
    return v;
  endfunction

  // Issue one refill and check address, latency, data and pulse width.
  task automatic read_line(input logic [31:0] addr, input logic [31:0] exp_ar, input int exp_lat);
    int r0;
    int n;
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = addr;
    #1 check("rd_rdy_accept", rd_rdy, 1'b1);
    r0 = ridx;
    @(negedge clk);
    rd_req = 1'b0;
    n = 1;
    while (!ret_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ret_valid_seen", ret_valid, 1'b1);
    if (exp_lat > 0) check("ret_latency", n, exp_lat);
    check("ret_data", ret_data, exp_line(r0));
    check("araddr", ar_cap, exp_ar);
    @(negedge clk);
    check("ret_valid_pulse", ret_valid, 1'b0);
    check("ret_data_held", ret_data, exp_line(r0));
  endtask

  task automatic wait_wr_valid(input int limit, output int n);
    n = 0;
    while (!wr_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wr_valid_seen", wr_valid, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    int w0;
    int wv;
    int rr;
    logic got_r;
    logic got_w;
    logic [127:0] rcap;

    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_rdy", rd_rdy, 1'b1);
    check("rst_wr_rdy", wr_rdy, 1'b1);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_ret_valid", ret_valid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_ret_data", ret_data, 128'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic refill: beats A0..A3, best-case latency 6.
    read_line(32'h1FC0_0014, 32'h1FC0_0010, 6);
    check("ret_data_a0_a3", ret_data, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);

    // Basic writeback with B three cycles after the last beat.
    bdelay = 3;
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 32'h0000_1008;
    wr_data = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
    #1 check("wr_rdy_accept", wr_rdy, 1'b1);
    w0 = widx;
    @(negedge clk);
    wr_req = 1'b0;
    check("awvalid_up", awvalid, 1'b1);
    check("awaddr_early", awaddr, 32'h0000_1000);
    check("wr_rdy_busy", wr_rdy, 1'b0);
    wait_wr_valid(100, n);
    check("aw_cap", aw_cap, 32'h0000_1000);
    check("w_beats", widx - w0, 4);
    check("w_words", {wcap[3], wcap[2], wcap[1], wcap[0]},
          128'h0000_4444_0000_3333_0000_2222_0000_1111);
    @(negedge clk);
    check("wr_valid_pulse", wr_valid, 1'b0);

    // Concurrent read and write with random stalls on every channel.
    stall_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = 32'h0000_444C + 32'(t << 8);
      wr_req  = 1'b1;
      wr_addr = 32'h0000_8884 + 32'(t << 8);
      wr_data = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001 ^ 128'(t);
      #1;
      check("st_rd_rdy", rd_rdy, 1'b1);
      check("st_wr_rdy", wr_rdy, 1'b1);
      r0 = ridx;
      w0 = widx;
      @(negedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
      check("st_both_busy", {rd_rdy, wr_rdy}, 2'b00);
      got_r = 1'b0;
      got_w = 1'b0;
      rcap  = '0;
      n = 0;
      while (!(got_r && got_w) && n < 400) begin
        if (ret_valid) begin
          got_r = 1'b1;
          rcap  = ret_data;
        end
        if (wr_valid) got_w = 1'b1;
        @(negedge clk);
        n++;
      end
      check("st_done", {got_r, got_w}, 2'b11);
      check("st_ret_data", rcap, exp_line(r0));
      check("st_araddr", ar_cap, 32'h0000_4440 + 32'(t << 8));
      check("st_awaddr", aw_cap, 32'h0000_8880 + 32'(t << 8));
      check("st_w_beats", widx - w0, 4);
      check("st_w_words", {wcap[3], wcap[2], wcap[1], wcap[0]},
            128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001 ^ 128'(t));
    end
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    // Same-line hazard: write 0x2000 pending, refill of 0x2004 held off,
    // refill of 0x3000 proceeds alongside the write.
    bdelay = 10;
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 32'h0000_2000;
    wr_data = 128'h5555_0004_5555_0003_5555_0002_5555_0001;
    #1 check("hz_wr_accept", wr_rdy, 1'b1);
    @(negedge clk);
    wr_req  = 1'b0;
    rd_addr = 32'h0000_2004;
    #1 check("hz_rd_blocked", rd_rdy, 1'b0);
    read_line(32'h0000_3000, 32'h0000_3000, 6);
    check("hz_wr_still_busy", wr_rdy, 1'b0);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 32'h0000_2004;
    wv = -1;
    rr = -1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (wr_valid) wv = k;
      if (rd_rdy) begin
        rr = k;
        break;
      end
      @(negedge clk);
    end
    r0 = ridx;
    check("hz_wr_valid_seen", wv >= 0, 1'b1);
    check("hz_rd_rdy_seen", rr >= 0, 1'b1);
    check("hz_release_cycle", rr - wv, 1);
    @(negedge clk);
    rd_req = 1'b0;
    n = 0;
    while (!ret_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hz_ret_valid", ret_valid, 1'b1);
    check("hz_ret_data", ret_data, exp_line(r0));
    check("hz_araddr", ar_cap, 32'h0000_2000);
    repeat (2) @(negedge clk);

    // Reset after the second R beat aborts the refill without a pulse.
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 32'h0000_5008;
    r0 = ridx;
    @(negedge clk);
    rd_req = 1'b0;
    n = 0;
    while (ridx < r0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mr_two_beats", ridx - r0, 2);
    resetn = 1'b0;
    #1;
    check("mr_arvalid", arvalid, 1'b0);
    check("mr_rready", rready, 1'b0);
    check("mr_ret_valid", ret_valid, 1'b0);
    check("mr_rd_rdy", rd_rdy, 1'b1);
    check("mr_wr_rdy", wr_rdy, 1'b1);
    check("mr_ret_data", ret_data, 128'h0);
    @(negedge clk);
    check("mr_no_pulse", ret_valid, 1'b0);
    resetn = 1'b1;
    read_line(32'h0000_6000, 32'h0000_6000, 6);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
